// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-ported word memory.
// Ports:
//   clk, reset                 - clock, asynchronous active-low reset
//   req/we/addr/wdata<n>       - requester n access request and operands (n = 0,1)
//   gnt<n>                     - combinational grant, only in IDLE
//   done/err/rdata<n>          - registered completion pulse, reject flag, read data
//   Address/Write_data/MemRead/MemWrite - shared memory port, active during ACCESS only
//   Mem_data                   - combinational read data from the memory
module mem_port_arbiter #(
    parameter int unsigned RAM_SIZE_BIT = 8,
    parameter bit          RR_EN        = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] Mem_data
);

    localparam int unsigned DW       = 32;
    localparam int unsigned RANGE_LO = RAM_SIZE_BIT + 2;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic          lat_we;
    logic          lat_id;
    logic [DW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          last_gnt;
    logic          any_req;
    logic          sel;
    logic          take;
    logic          reject;
    logic          acc_ok;
    logic [DW-1:0] rd_res;

    // Rejection is judged on the latched operands during ACCESS.
    assign reject = (lat_addr[1:0] != 2'b00) || ((lat_addr >> RANGE_LO) != DW'(0));

    // Next state, arbitration and memory-port drive.
    always_comb begin
        state_nxt  = state;
        any_req    = req0 | req1;
        sel        = 1'b0;
        take       = 1'b0;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        acc_ok     = 1'b0;
        Address    = '0;
        Write_data = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        rd_res     = '0;

        // Tie goes to the port not granted last (round-robin) or to port 0.
        if (req0 && req1) begin
            sel = RR_EN ? ~last_gnt : 1'b0;
        end else begin
            sel = ~req0;
        end

        case (state)
            IDLE: begin
                if (any_req) begin
                    take      = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = IDLE;
                acc_ok    = ~reject;
            end
            default: state_nxt = IDLE;
        endcase

        // Grant is gated by reset so every output reads 0 while reset is held.
        gnt0 = take & reset & ~sel;
        gnt1 = take & reset & sel;

        if (acc_ok) begin
            Address    = lat_addr;
            Write_data = lat_we ? lat_wdata : '0;
            MemRead    = ~lat_we;
            MemWrite   = lat_we;
            rd_res     = lat_we ? '0 : Mem_data;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch and completion registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_id    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            last_gnt  <= 1'b1;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            if (take) begin
                lat_we    <= sel ? we1 : we0;
                lat_addr  <= sel ? addr1 : addr0;
                lat_wdata <= sel ? wdata1 : wdata0;
                lat_id    <= sel;
                last_gnt  <= sel;
            end
            if (state == ACCESS) begin
                if (lat_id) begin
                    done1  <= 1'b1;
                    err1   <= reject;
                    rdata1 <= rd_res;
                end else begin
                    done0  <= 1'b1;
                    err0   <= reject;
                    rdata0 <= rd_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// reset/tie/withdraw sequences, then random traffic against a transaction model.
module tb_mem_port_arbiter;

    localparam int unsigned RSB = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic [31:0] rdata0, rdata1, Address, Write_data;
    logic        MemRead, MemWrite;
    logic [31:0] Mem_data;

    logic        fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_err0, fp_err1;
    logic [31:0] fp_rdata0, fp_rdata1, fp_address, fp_write_data;
    logic        fp_mem_read, fp_mem_write;
    wire  [31:0] fp_mem_data = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.RAM_SIZE_BIT(RSB), .RR_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
        .Address(Address), .Write_data(Write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .Mem_data(Mem_data)
    );

    mem_port_arbiter #(.RAM_SIZE_BIT(RSB), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(fp_gnt0), .gnt1(fp_gnt1), .done0(fp_done0), .done1(fp_done1),
        .err0(fp_err0), .err1(fp_err1), .rdata0(fp_rdata0), .rdata1(fp_rdata1),
        .Address(fp_address), .Write_data(fp_write_data),
        .MemRead(fp_mem_read), .MemWrite(fp_mem_write), .Mem_data(fp_mem_data)
    );

    function automatic logic [31:0] init_val(input int idx);
        if (idx == 1) return 32'h2084_1234;
        return (32'(idx) * 32'h0100_0193) ^ 32'h5A5A_0000;
    endfunction

    // Memory environment seen by the round-robin instance.
    bit [31:0] env_mem [256];
    bit        env_wr  [256];
    always @(posedge clk) begin
        if (MemWrite) begin
            env_mem[Address[RSB+1:2]] <= Write_data;
            env_wr[Address[RSB+1:2]]  <= 1'b1;
        end
    end
    always_comb begin
        Mem_data = env_wr[Address[RSB+1:2]] ? env_mem[Address[RSB+1:2]] : init_val(int'(Address[RSB+1:2]));
    end

    // Reference memory contents, updated by the bench's own model.
    logic [31:0] ref_mem [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a % 4 == 0) && (longint'(a) < (longint'(1) << (RSB + 2)));
    endfunction

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_mr;
        logic        exp_mw;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    // One isolated transaction from IDLE: grant, memory cycle, completion.
    task automatic run_vec(input vec_t v);
        set_port(v.port, 1'b1, v.we, v.addr, v.wdata);
        @(negedge clk);
        chkb("vec_gnt0", gnt0, v.port == 0);
        chkb("vec_gnt1", gnt1, v.port == 1);
        @(posedge clk); #1;
        set_port(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chkb("vec_memread", MemRead, v.exp_mr);
        chkb("vec_memwrite", MemWrite, v.exp_mw);
        chk("vec_address", Address, (v.exp_mr || v.exp_mw) ? v.addr : 32'h0);
        chk("vec_write_data", Write_data, v.exp_mw ? v.wdata : 32'h0);
        if (v.exp_mw) ref_mem[v.addr[RSB+1:2]] = v.wdata;
        @(negedge clk);
        chkb("vec_done", (v.port == 0) ? done0 : done1, 1'b1);
        chkb("vec_err", (v.port == 0) ? err0 : err1, v.exp_err);
        chk("vec_rdata", (v.port == 0) ? rdata0 : rdata1, v.exp_rd);
        chkb("vec_memwrite_after", MemWrite, 1'b0);
        @(negedge clk);
        chkb("vec_done_pulse_end", (v.port == 0) ? done0 : done1, 1'b0);
        @(posedge clk); #1;
    endtask

    // Random-phase model state (transaction level).
    int          m_busy, m_last;
    bit          m_pend, m_dv, m_derr;
    int          m_dp, p_port;
    logic        p_we;
    logic [31:0] p_addr, p_wdata, m_res;
    logic [31:0] exp_rd [2];
    int          g;
    bit          granted [2];
    bit          ok;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        vecs[0] = '{0, 1'b0, 32'h0000_0004, 32'h0,         1'b1, 1'b0, 1'b0, 32'h2084_1234};
        vecs[1] = '{1, 1'b1, 32'h0000_0080, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[2] = '{1, 1'b0, 32'h0000_0080, 32'h0,         1'b1, 1'b0, 1'b0, 32'h1234_5678};
        vecs[3] = '{0, 1'b0, 32'h0000_0006, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0};
        vecs[4] = '{0, 1'b0, 32'h0000_0400, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0};
        vecs[5] = '{0, 1'b1, 32'h0000_00A0, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[6] = '{0, 1'b0, 32'h0000_00A0, 32'h0,         1'b1, 1'b0, 1'b0, 32'hCAFE_F00D};
        vecs[7] = '{1, 1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0};

        // Reset holds every output low even with a request pending.
        reset = 1'b0;
        set_port(0, 1'b1, 1'b0, 32'h4, 32'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #23;
        chkb("rst_gnt0", gnt0, 1'b0);
        chkb("rst_memread", MemRead, 1'b0);
        chk("rst_address", Address, 32'h0);
        chkb("rst_done0", done0, 1'b0);
        chk("rst_rdata0", rdata0, 32'h0);
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during the ACCESS cycle of a write.
        set_port(0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        @(negedge clk);
        chkb("rmw_gnt0", gnt0, 1'b1);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chkb("rmw_memwrite_before", MemWrite, 1'b1);
        #2 reset = 1'b0;
        #1;
        chkb("rmw_memwrite_async", MemWrite, 1'b0);
        chk("rmw_address_async", Address, 32'h0);
        @(posedge clk); #1;
        chkb("rmw_done0", done0, 1'b0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chkb("rmw_done0_after", done0, 1'b0);
        chk("rmw_rdata0_after", rdata0, 32'h0);
        chk("rmw_rdata1_after", rdata1, 32'h0);

        // Continuous tie right after reset release.
        set_port(0, 1'b1, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h4, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chkb("tie_rr_gnt0", gnt0, (i % 2 == 0) && ((i / 2) % 2 == 0));
            chkb("tie_rr_gnt1", gnt1, (i % 2 == 0) && ((i / 2) % 2 == 1));
            chkb("tie_fp_gnt0", fp_gnt0, i % 2 == 0);
            chkb("tie_fp_gnt1", fp_gnt1, 1'b0);
            @(posedge clk); #1;
        end
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        // Request raised during ACCESS and withdrawn before the next IDLE.
        set_port(0, 1'b1, 1'b0, 32'h8, 32'h0);
        @(negedge clk);
        chkb("wd_gnt0", gnt0, 1'b1);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b1, 1'b1, 32'hC, 32'h5555_AAAA);
        @(negedge clk);
        chkb("wd_gnt1_access", gnt1, 1'b0);
        chkb("wd_memread_port0", MemRead, 1'b1);
        @(posedge clk); #1;
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chkb("wd_gnt1", gnt1, 1'b0);
            chkb("wd_memread", MemRead, 1'b0);
            chkb("wd_memwrite", MemWrite, 1'b0);
            chkb("wd_done1", done1, 1'b0);
            @(posedge clk); #1;
        end

        // Random traffic against the transaction model, from a fresh reset.
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        m_busy = 0; m_last = 1; m_pend = 1'b0; m_dv = 1'b0;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        granted[0] = 1'b0; granted[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                logic cur;
                cur = (p == 0) ? req0 : req1;
                if (granted[p] || !cur) begin
                    if ($urandom_range(0, 1) == 1) begin
                        logic [31:0] a;
                        int k;
                        k = int'($urandom_range(0, 7));
                        a = 32'($urandom_range(0, 15)) << 2;
                        if (k == 0) a = a | 32'($urandom_range(1, 3));
                        else if (k == 1) a = a | (32'h1 << $urandom_range(10, 31));
                        set_port(p, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
                    end else begin
                        set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
                end
            end
            @(negedge clk);
            g = -1;
            if (m_busy == 0) begin
                if (req0 && req1) g = 1 - m_last;
                else if (req0) g = 0;
                else if (req1) g = 1;
            end
            chkb("rnd_gnt0", gnt0, g == 0);
            chkb("rnd_gnt1", gnt1, g == 1);
            ok = m_pend && addr_ok(p_addr);
            chkb("rnd_memread", MemRead, ok && !p_we);
            chkb("rnd_memwrite", MemWrite, ok && p_we);
            chk("rnd_address", Address, ok ? p_addr : 32'h0);
            chk("rnd_write_data", Write_data, (ok && p_we) ? p_wdata : 32'h0);
            chkb("rnd_done0", done0, m_dv && m_dp == 0);
            chkb("rnd_done1", done1, m_dv && m_dp == 1);
            chk("rnd_rdata0", rdata0, exp_rd[0]);
            chk("rnd_rdata1", rdata1, exp_rd[1]);
            if (m_dv) chkb("rnd_err", (m_dp == 0) ? err0 : err1, m_derr);
            // Advance the model by one cycle.
            m_dv = m_pend;
            if (m_pend) begin
                m_dp   = p_port;
                m_derr = !ok;
                m_res  = (ok && !p_we) ? ref_mem[p_addr / 4] : 32'h0;
                if (ok && p_we) ref_mem[p_addr / 4] = p_wdata;
                exp_rd[p_port] = m_res;
            end
            m_pend = (g >= 0);
            if (g >= 0) begin
                p_port  = g;
                p_we    = (g == 0) ? we0 : we1;
                p_addr  = (g == 0) ? addr0 : addr1;
                p_wdata = (g == 0) ? wdata0 : wdata1;
                m_last  = g;
            end
            m_busy = (g >= 0) ? 1 : 0;
            granted[0] = (g == 0);
            granted[1] = (g == 1);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
